// File: rtl/mem_arbiter_if.sv
// Bundle of every handshake and bus signal around mem_arbiter: the IF
// requester, the D (load/store) requester and the memory port.
// The arbiter uses the master modport because it is the memory's master.
// The slave modport is the surrounding system: requesters plus memory.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_resp_valid;
  logic                  if_resp_ready;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  d_req_valid;
  logic                  d_req_ready;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic                  d_wen;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [STRB_WIDTH-1:0] d_wstrb;
  logic                  d_resp_valid;
  logic                  d_resp_ready;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [STRB_WIDTH-1:0] mem_wstrb;
  logic                  mem_resp_valid;
  logic                  mem_resp_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  if_req_valid, if_addr, if_resp_ready,
    input  d_req_valid, d_addr, d_wen, d_wdata, d_wstrb, d_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output if_req_ready, if_resp_valid, if_rdata,
    output d_req_ready, d_resp_valid, d_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_resp_ready
  );

  modport slave (
    output if_req_valid, if_addr, if_resp_ready,
    output d_req_valid, d_addr, d_wen, d_wdata, d_wstrb, d_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  if_req_ready, if_resp_valid, if_rdata,
    input  d_req_ready, d_resp_valid, d_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_resp_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the instruction
// fetch (IF, read only) and load/store (D) requesters of the multi-cycle CPU.
// Only one transaction is in flight. The request is granted and registered,
// then forwarded to memory, and the response is routed back to its owner.
// Optional macro ARB_ROUND_ROBIN_EN: when both requesters are present, the
// one that did not win last time wins. Without it, D always beats IF.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic           clk_i,
  input logic           rst_ni,
  mem_arbiter_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  owner_q, owner_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  winD;
  logic                  winIf;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastOwner_q, lastOwner_d;

  assign winD  = bus.d_req_valid && (!bus.if_req_valid || !lastOwner_q);

  // Record who won each grant so the other side wins the next contested one
  always_comb begin
    lastOwner_d = lastOwner_q;
    if ((state_q == IDLE) && (winD || winIf)) begin
      lastOwner_d = winD;
    end
  end

  // Last-winner register; IF counts as the last winner after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lastOwner_q <= 1'b0;
    end else begin
      lastOwner_q <= lastOwner_d;
    end
  end
`else
  assign winD  = bus.d_req_valid;
`endif
  assign winIf = bus.if_req_valid && !winD;

  // The memory request is driven only from the registered fields
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

  // Next state, field capture and all handshake outputs
  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    wen_d              = wen_q;
    wdata_d            = wdata_q;
    wstrb_d            = wstrb_q;
    owner_d            = owner_q;
    rdata_d            = rdata_q;
    bus.if_req_ready   = 1'b0;
    bus.d_req_ready    = 1'b0;
    bus.if_resp_valid  = 1'b0;
    bus.d_resp_valid   = 1'b0;
    bus.if_rdata       = '0;
    bus.d_rdata        = '0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_resp_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.d_req_ready  = winD && rst_ni;
        bus.if_req_ready = winIf && rst_ni;
        if (winD) begin
          addr_d  = bus.d_addr;
          wen_d   = bus.d_wen;
          wdata_d = bus.d_wdata;
          wstrb_d = bus.d_wstrb;
          owner_d = 1'b1;
          state_d = REQ;
        end else if (winIf) begin
          addr_d  = bus.if_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wstrb_d = '0;
          owner_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        bus.mem_resp_ready = 1'b1;
        if (bus.mem_resp_valid) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (owner_q) begin
          bus.d_resp_valid = 1'b1;
          bus.d_rdata      = rdata_q;
          if (bus.d_resp_ready) begin
            state_d = IDLE;
          end
        end else begin
          bus.if_resp_valid = 1'b1;
          bus.if_rdata      = rdata_q;
          if (bus.if_resp_ready) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered transaction fields; reset drops any transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      owner_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported memory between the instruction-fetch requester (IF, read-only) and the load/store requester (D, read/write with byte strobes) of the multi-cycle mips_cpu.
Each requester uses a valid/ready request channel and a valid/ready response channel. The memory side uses the same pair of channels.
One transaction is in flight at a time. The block grants, registers and forwards the request, then routes the memory response back to the granted requester.

Parameters:
ADDR_WIDTH, 32, width of every address port
DATA_WIDTH, 32, width of every data port; strobe width is DATA_WIDTH/8

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  reset, asynchronous, active-low; clears all state
if_req_valid  in  1  IF read request present
if_req_ready  out  1  IF request accepted this cycle
if_addr  in  ADDR_WIDTH  IF read address
if_resp_valid  out  1  IF response data valid
if_resp_ready  in  1  IF takes the response
if_rdata  out  DATA_WIDTH  IF read data
d_req_valid  in  1  D request present
d_req_ready  out  1  D request accepted this cycle
d_addr  in  ADDR_WIDTH  D address
d_wen  in  1  1 = write, 0 = read
d_wdata  in  DATA_WIDTH  D write data
d_wstrb  in  DATA_WIDTH/8  D byte strobes
d_resp_valid  out  1  D response valid (read data, or write acknowledge)
d_resp_ready  in  1  D takes the response
d_rdata  out  DATA_WIDTH  D read data
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts the request
mem_addr  out  ADDR_WIDTH  registered address
mem_wen  out  1  registered write enable
mem_wdata  out  DATA_WIDTH  registered write data
mem_wstrb  out  DATA_WIDTH/8  registered strobes; forced to 0 for IF reads
mem_resp_valid  in  1  memory response present
mem_resp_ready  out  1  arbiter takes the memory response
mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- States: IDLE, REQ, WAIT, RESP. State is held in a 2-bit register. Transitions happen on the clk edge.
- IDLE:
  - *_req_ready is asserted combinationally, only toward the winner, and only when that winner's req_valid is 1.
  - On the accept edge the block latches addr, wen, wdata, wstrb and owner into registers, then goes to REQ.
  - An IF accept stores wen=0 and wstrb=0.
- REQ: mem_req_valid=1, driven only from the registered fields. On mem_req_ready=1 go to WAIT. Otherwise hold, with all fields stable.
- WAIT: mem_resp_ready=1. On mem_resp_valid=1, latch mem_rdata into the response register and go to RESP. The data is latched for writes too; D ignores it.
- RESP:
  - The owner's *_resp_valid=1 and *_rdata = response register.
  - The non-owner's resp_valid=0 and its rdata=0.
  - On the owner's resp_ready=1 go to IDLE.
- Minimum latency with mem_req_ready=1 and a one-cycle memory: accept at cycle 0, REQ at cycle 1, WAIT at cycle 2, resp_valid at cycle 3. The next accept is possible at cycle 4.
- Outside IDLE, both req_ready outputs are 0. Requests are never accepted while a transaction is in flight.
- Default arbitration is fixed priority: D beats IF when both valid are 1 in IDLE.
- mem_resp_valid outside WAIT is ignored. mem_resp_ready is 0 outside WAIT.
- Reset (rst=0), at any time:
  - The state goes to IDLE and any in-flight transaction is dropped with no response.
  - All registered fields and the response register clear to 0.
  - All valid and ready outputs go to 0 immediately.
  - The block resumes on the first edge after rst returns to 1.
- Requesters keep valid and payload stable until ready. The arbiter samples the payload only on the accept edge.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: a last_owner register (reset value IF) selects the winner when both requests are present; the requester that did not win last time wins. A single requester always wins immediately.
- Undefined: fixed priority, D over IF. last_owner is not implemented.

Test Plan:
- IF-only read, addr=0x0000_0040, mem_rdata=0x2408_0005, one-cycle memory -> if_req_ready at cycle 0, mem_req_valid at cycle 1 with mem_wstrb=0, if_resp_valid at cycle 3 with if_rdata=0x2408_0005.
- D write addr=0x100, wdata=0xDEAD_BEEF, wstrb=4'b0011 -> mem_wen=1, mem_wdata=0xDEAD_BEEF, mem_wstrb=4'b0011; d_resp_valid follows mem_resp_valid; if_resp_valid stays 0.
- Both valid in IDLE, three back-to-back transactions -> without the macro, grants D,D,D while d_req_valid is held; with ARB_ROUND_ROBIN_EN, grants D,IF,D.
- mem_req_ready held at 0 for 5 cycles in REQ, and d_resp_ready held at 0 for 3 cycles in RESP -> mem_addr/mem_wdata stable throughout; d_resp_valid stays high; no new request is accepted.
- rst pulled to 0 in WAIT, then mem_resp_valid=1 arrives after release -> no resp_valid to either requester; state is IDLE; the next if_req_valid is accepted immediately.
- Read of addr=0x3FC while IF is pending -> the D transaction completes first; the IF request is accepted in the IDLE cycle after D's response handshake.
